// File: rtl/rsp_fifo_arbiter_if.sv
// Requester-side and FIFO-side handshake bundle for rsp_fifo_arbiter.
// master: requesters plus FIFO status (the environment); slave: the arbiter.
interface rsp_fifo_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data;   // [i] == flat [i*DATA_W +: DATA_W]
    logic [NUM_REQ-1:0]             req_last;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           rsp_fifo_full;
    logic [DATA_W-1:0]              rsp_fifo_data;
    logic                           rsp_fifo_write;

    modport master (
        output req_valid, req_data, req_last, rsp_fifo_full,
        input  req_ready, rsp_fifo_data, rsp_fifo_write
    );

    modport slave (
        input  req_valid, req_data, req_last, rsp_fifo_full,
        output req_ready, rsp_fifo_data, rsp_fifo_write
    );
endinterface

// File: rtl/rsp_fifo_arbiter.sv
// rsp_fifo_arbiter: round-robin, packet-atomic sharing of the HPS response FIFO
// write port among NUM_REQ requesters. One arbitration cycle per packet, then
// one word per cycle until the owner's last word is accepted.
// Optional feature macro: RSP_ARB_TIMEOUT_EN (stall timeout that aborts a grant).
module rsp_fifo_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    rsp_fifo_arbiter_if.slave          bus,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       timeout_pulse
);
    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic {ARB_IDLE = 1'b0, ARB_XFER = 1'b1} arb_state_t;

    arb_state_t        state, state_nxt;
    logic [GW-1:0]     rr_ptr;
    logic [GW-1:0]     pick;
    logic [GW-1:0]     next_owner;
    logic [GW:0]       scan_idx;
    logic              any_valid;
    logic              accept;
    logic              owner_last;
    logic              abort;
    logic [DATA_W-1:0] data_q;
    logic              write_q;

    assign any_valid  = |bus.req_valid;
    assign accept     = (state == ARB_XFER) && bus.req_valid[grant_id] && !bus.rsp_fifo_full;
    assign owner_last = bus.req_last[grant_id];
    assign next_owner = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);
    assign busy       = (state == ARB_XFER);

    assign bus.rsp_fifo_data  = data_q;
    assign bus.rsp_fifo_write = write_q;

    // Rotating-priority scan: walk from the highest offset down so the
    // requester closest to rr_ptr is the one left in pick.
    always_comb begin
        pick     = '0;
        scan_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, rr_ptr} + (GW+1)'(k);
            if (scan_idx >= (GW+1)'(NUM_REQ))
                scan_idx = scan_idx - (GW+1)'(NUM_REQ);
            if (bus.req_valid[scan_idx[GW-1:0]])
                pick = scan_idx[GW-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ARB_IDLE;
        else       state <= state_nxt;
    end

    // Next state and the owner's combinational ready (drops with FIFO full).
    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        case (state)
            ARB_IDLE: begin
                if (any_valid) state_nxt = ARB_XFER;
            end
            ARB_XFER: begin
                bus.req_ready[grant_id] = !bus.rsp_fifo_full;
                if ((accept && owner_last) || abort) state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Grant capture, registered FIFO write, and round-robin pointer advance
    // (pointer moves only when a packet completes or is aborted).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr   <= '0;
            grant_id <= '0;
            data_q   <= '0;
            write_q  <= 1'b0;
        end else begin
            write_q <= accept;
            if (accept)
                data_q <= bus.req_data[grant_id];
            if (state == ARB_IDLE && any_valid)
                grant_id <= pick;
            if ((accept && owner_last) || abort)
                rr_ptr <= next_owner;
        end
    end

`ifdef RSP_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] stall_cnt;

    // Abort on the cycle that would be the TIMEOUT_CYCLES-th owner-idle cycle.
    assign abort = (state == ARB_XFER) && !accept && !bus.rsp_fifo_full &&
                   (stall_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Stall counter: frozen while the FIFO is full, cleared by any accept or
    // outside a transfer; pulse is the registered abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt     <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= abort;
            if (state != ARB_XFER || accept)
                stall_cnt <= '0;
            else if (!bus.rsp_fifo_full)
                stall_cnt <= stall_cnt + CW'(1);
        end
    end
`else
    assign abort         = 1'b0;
    assign timeout_pulse = 1'b0;

    // The stall limit has no effect in this build; keep it referenced so the
    // parameter is still part of the elaborated configuration.
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_limit_unused
    end
`endif
endmodule
